// File: rtl/qos_request_agent.sv
// -----------------------------------------------------------------------------
// qos_request_agent
//   Requester-side agent for the QoS arbiter (one instance per core).
//   Local requests, each carrying a qos_config_t and an opaque tag, are queued
//   in a small FIFO. The FIFO head is offered to the arbiter and held until it
//   is granted. While the head waits, its qos_level is escalated one step every
//   AGE_THRESHOLD cycles so a low-priority requester cannot starve.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop every buffered request (takes effect next cycle)
//   src_valid_i/ready_o  local request handshake; src_ready_o = !full
//   src_qos_config_i     QoS config of the local request
//   src_tag_i            tag of the local request
//   req_valid_o/ready_i  arbiter handshake; req_valid_o = !empty
//   req_qos_config_o     head config with qos_level replaced by the aged level
//   req_tag_o            head tag
//   granted_o            one-cycle pulse, registered from the grant cycle
//   granted_tag_o        tag of the granted request, valid with granted_o
//   occupancy_o          number of entries held
//   dbg_state_o          agent FSM state (IDLE = empty, WAIT = head offered)
//
// Handshakes: a transfer happens on a cycle where valid && ready are both high
// at the rising clock edge. Valid never depends on ready. On the request side
// the head (tag and non-level config fields) is held stable while
// req_valid_o=1 and not yet granted; only qos_level may rise through aging.
// -----------------------------------------------------------------------------
package qos_pkg;
    typedef enum logic [2:0] {
        QOS_LOW         = 3'd0,
        QOS_MEDIUM      = 3'd1,
        QOS_MEDIUM_HIGH = 3'd2,
        QOS_HIGH        = 3'd3,
        QOS_CRITICAL    = 3'd4
    } qos_level_e;

    typedef struct packed {
        qos_level_e  qos_level;
        logic [3:0]  weight;
        logic        urgent;
    } qos_config_t;

    typedef enum logic {
        AGENT_IDLE = 1'b0,
        AGENT_WAIT = 1'b1
    } agent_state_e;
endpackage

module qos_request_agent
    import qos_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int TAG_W         = 8,
    parameter int AGE_THRESHOLD = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       src_valid_i,
    output logic                       src_ready_o,
    input  qos_config_t                src_qos_config_i,
    input  logic [TAG_W-1:0]           src_tag_i,
    output logic                       req_valid_o,
    input  logic                       req_ready_i,
    output qos_config_t                req_qos_config_o,
    output logic [TAG_W-1:0]           req_tag_o,
    output logic                       granted_o,
    output logic [TAG_W-1:0]           granted_tag_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output agent_state_e               dbg_state_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = (AGE_THRESHOLD > 0) ? $clog2(AGE_THRESHOLD + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_LAST =
        AGE_W'((AGE_THRESHOLD > 0) ? (AGE_THRESHOLD - 1) : 0);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage
    qos_config_t        r_cfg_mem [DEPTH];
    logic [TAG_W-1:0]   r_tag_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_rd_ptr;

    agent_state_e       r_state;
    agent_state_e       w_state_nxt;
    logic [AGE_W-1:0]   r_age;
    logic [AGE_W-1:0]   w_age_nxt;
    qos_level_e         r_cur_level;
    qos_level_e         w_level_nxt;
    logic               r_granted;
    logic [TAG_W-1:0]   r_granted_tag;

    logic [CNT_W-1:0]   w_occ;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_wr_en;
    logic               w_pop;
    logic [PTR_W-1:0]   w_head_idx;
    logic [PTR_W-1:0]   w_next_idx;

    // One escalation step, saturating at CRITICAL.
    function automatic qos_level_e f_step(input qos_level_e lvl);
        if (lvl < QOS_CRITICAL) begin
            f_step = qos_level_e'(lvl + 3'd1);
        end else begin
            f_step = lvl;
        end
    endfunction

    assign w_occ      = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_occ == FULL_CNT);
    assign w_empty    = (w_occ == '0);
    assign w_push     = src_valid_i && !w_full;
    // A push in the flush cycle is accepted by the handshake but discarded.
    assign w_wr_en    = w_push && !flush_i;
    assign w_pop      = !w_empty && req_ready_i;
    assign w_head_idx = r_rd_ptr[PTR_W-1:0];
    assign w_next_idx = w_head_idx + PTR_W'(1);

    // Next state, age counter and presented level.
    always_comb begin
        w_state_nxt = r_state;
        w_age_nxt   = r_age;
        w_level_nxt = r_cur_level;
        case (r_state)
            AGENT_IDLE: begin
                if (w_push) begin
                    w_state_nxt = AGENT_WAIT;
                    w_age_nxt   = '0;
                    w_level_nxt = src_qos_config_i.qos_level;
                end
            end
            AGENT_WAIT: begin
                if (w_pop) begin
                    // New head starts fresh: its own level, age zero.
                    w_age_nxt = '0;
                    if (w_occ > CNT_W'(1)) begin
                        w_level_nxt = r_cfg_mem[w_next_idx].qos_level;
                    end else if (w_push) begin
                        // Last entry leaves while a new one arrives: the
                        // incoming request becomes the head.
                        w_level_nxt = src_qos_config_i.qos_level;
                    end else begin
                        w_state_nxt = AGENT_IDLE;
                    end
                end else if (AGE_THRESHOLD != 0) begin
                    if (r_age == AGE_LAST) begin
                        w_age_nxt   = '0;
                        w_level_nxt = f_step(r_cur_level);
                    end else begin
                        w_age_nxt = r_age + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = AGENT_IDLE;
            end
        endcase
        if (flush_i) begin
            w_state_nxt = AGENT_IDLE;
            w_age_nxt   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= AGENT_IDLE;
            r_age         <= '0;
            r_cur_level   <= QOS_LOW;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_granted     <= 1'b0;
            r_granted_tag <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_age       <= w_age_nxt;
            r_cur_level <= w_level_nxt;
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + CNT_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + CNT_W'(1);
                end
            end
            // The grant pulse is reported even when the same cycle flushes.
            r_granted <= w_pop;
            if (w_pop) begin
                r_granted_tag <= r_tag_mem[w_head_idx];
            end
        end
    end

    // Data storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_cfg_mem[r_wr_ptr[PTR_W-1:0]] <= src_qos_config_i;
            r_tag_mem[r_wr_ptr[PTR_W-1:0]] <= src_tag_i;
        end
    end

    always_comb begin
        req_qos_config_o           = r_cfg_mem[w_head_idx];
        req_qos_config_o.qos_level = r_cur_level;
    end

    assign src_ready_o   = !w_full;
    assign req_valid_o   = !w_empty;
    assign req_tag_o     = r_tag_mem[w_head_idx];
    assign granted_o     = r_granted;
    assign granted_tag_o = r_granted_tag;
    assign occupancy_o   = w_occ;
    assign dbg_state_o   = r_state;

endmodule
